instr_line_refill: RTL and testbench
====================================

// Module: instr_line_refill
// PURPOSE
//  Memory-side responder for the instruction cache miss path.
//  - Accepts one line-fill request at a time from the cache.
//  - Reads the line's words one by one from the word-wide backing instruction memory.
//  - Packs them into one 64-bit line and returns it with a one-cycle valid pulse.
//  - Sits between the instruction cache and instruction memory in the fetch stage.
// PARAMETERS
//  ADDR_W          16  width of word addresses (PC-granular, one address per 16-bit instruction)
//  WORD_W          16  width of one memory word / instruction
//  WORDS_PER_LINE  4   words per cache line; must be a power of 2; WORD_W*WORDS_PER_LINE = line width (64)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  miss_req     in   1       cache requests a line fill; held high until miss_ack
//  miss_addr    in   ADDR_W  address of the missing instruction; stable while miss_req is high
//  miss_ack     out  1       1-cycle pulse: request accepted
//  flush        in   1       abort any fill in progress (branch redirect)
//  busy         out  1       high from acceptance until return to IDLE
//  mem_rd_en    out  1       1-cycle read strobe to instruction memory
//  mem_addr     out  ADDR_W  word address for mem_rd_en
//  mem_rd_valid in   1       read data valid; L>=1 cycles after mem_rd_en
//  mem_rd_data  in   WORD_W  read data, qualified by mem_rd_valid
//  line_valid   out  1       1-cycle pulse: line_data/line_addr valid
//  line_addr    out  ADDR_W  line base = miss_addr with low log2(WORDS_PER_LINE) bits cleared
//  line_data    out  64      word at offset i in bits [WORD_W*i+WORD_W-1 : WORD_W*i]
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; line_data, line_addr and word counter cleared. Reset mid-fill abandons the fill; a late mem_rd_valid after reset is ignored.
//  FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
//  IDLE
//   - miss_req && !flush: miss_ack=1 in that cycle; latch base and start offset; clear counter; go to ISSUE.
//   - flush has priority over miss_req: request is not acked.
//  ISSUE
//   - mem_rd_en=1 for exactly one cycle; mem_addr = base | offset; go to WAIT.
//  WAIT
//   - On mem_rd_valid: write mem_rd_data into its line slot; counter += 1.
//   - If counter was WORDS_PER_LINE-1, go to DONE; otherwise ISSUE with offset+1 modulo WORDS_PER_LINE (wraps within the line, never crosses it).
//  DONE
//   - line_valid=1 for one cycle with line_addr/line_data; go to IDLE. busy drops on the IDLE cycle.
//  Flush
//   - In ISSUE or DONE: go to IDLE immediately; no line_valid.
//   - In WAIT: go to DRAIN; stay until mem_rd_valid; discard that data; then IDLE. Exactly one read is ever outstanding.
//   - Flush in the same cycle as mem_rd_valid in WAIT: data discarded; go to IDLE directly.
//  mem_rd_valid outside WAIT/DRAIN is ignored.
//  Latency: ack at cycle T -> line_valid at T+1+WORDS_PER_LINE*(L+1). With L=1: T+9.
//  Throughput: next miss_ack possible the cycle after DONE. One line per fill.
//  line_data holds its value until the next fill writes a slot. Consumers use it only when line_valid=1.
// CONFIGURATION
//  CRITICAL_WORD_FIRST_EN
//   - Defined: start offset = miss_addr low bits. Fetch order wraps, e.g. offset 2 -> 2,3,0,1.
//   - Not defined: start offset = 0. Words are always fetched 0..WORDS_PER_LINE-1.
//   - Packing, line_addr and latency are identical in both builds.
// TESTING
//  1 Basic fill
//   - Stimulus: no macro, L=1, miss_addr=0x0012; mem returns data = addr ^ 0xA000.
//   - Response: reads 0x10,0x11,0x12,0x13; line_valid at T+9; line_addr=0x0010; line_data=64'hA013_A012_A011_A010.
//  2 Critical word first
//   - Stimulus: CRITICAL_WORD_FIRST_EN defined, same request as test 1.
//   - Response: read order 0x12,0x13,0x10,0x11; line_data identical to test 1.
//  3 Flush mid-fill
//   - Stimulus: L=3; flush while in WAIT on the second word.
//   - Response: no further mem_rd_en; outstanding valid discarded; no line_valid; busy=0 after drain; next request acked normally.
//  4 Reset mid-fill
//   - Stimulus: rst_n low in WAIT; stray mem_rd_valid 1 cycle after release.
//   - Response: all outputs 0; state IDLE; stray data ignored.
//  5 Back-to-back requests
//   - Stimulus: miss_req held through DONE with new addr 0x0047.
//   - Response: ack on the cycle after line_valid; line_addr=0x0044.
//  6 Flush/request collision
//   - Stimulus: flush and miss_req high together in IDLE.
//   - Response: no ack; request acked on the next cycle once flush drops.

Source files
------------

// File: rtl/instr_line_refill_if.sv
// Signal bundle between instr_line_refill, the instruction cache and instruction memory.
// slave: the refill engine; master: the cache/memory side that drives requests and read data.
interface instr_line_refill_if #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned WORD_W         = 16,
   parameter int unsigned WORDS_PER_LINE = 4
);
   logic                             miss_req;
   logic [ADDR_W-1:0]                miss_addr;
   logic                             miss_ack;
   logic                             flush;
   logic                             busy;
   logic                             mem_rd_en;
   logic [ADDR_W-1:0]                mem_addr;
   logic                             mem_rd_valid;
   logic [WORD_W-1:0]                mem_rd_data;
   logic                             line_valid;
   logic [ADDR_W-1:0]                line_addr;
   logic [WORD_W*WORDS_PER_LINE-1:0] line_data;

   modport master (
      output miss_req, miss_addr, flush, mem_rd_valid, mem_rd_data,
      input  miss_ack, busy, mem_rd_en, mem_addr, line_valid, line_addr, line_data
   );

   modport slave (
      input  miss_req, miss_addr, flush, mem_rd_valid, mem_rd_data,
      output miss_ack, busy, mem_rd_en, mem_addr, line_valid, line_addr, line_data
   );
endinterface

// File: rtl/instr_line_refill.sv
// Instruction-cache line refill: fetches one line word by word from memory and returns it packed.
// Optional CRITICAL_WORD_FIRST_EN starts the fetch at the missing word and wraps within the line.
module instr_line_refill #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned WORD_W         = 16,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input logic                clk,
   input logic                rst_n,
   instr_line_refill_if.slave bus
);
   localparam int unsigned OFF_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;
   localparam logic [OFF_W-1:0] LastCnt = OFF_W'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] base_q;
   logic [OFF_W-1:0]  off_q;
   logic [OFF_W-1:0]  cnt_q;
   logic [LINE_W-1:0] line_q;

   logic              accept;
   logic [ADDR_W-1:0] req_base;
   logic [OFF_W-1:0]  start_off;

   assign accept   = rst_n && (state_q == StIdle) && bus.miss_req && !bus.flush;
   assign req_base = bus.miss_addr & ~ADDR_W'(WORDS_PER_LINE - 1);

`ifdef CRITICAL_WORD_FIRST_EN
   assign start_off = bus.miss_addr[OFF_W-1:0];
`else
   assign start_off = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         base_q  <= '0;
         off_q   <= '0;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  base_q  <= req_base;
                  off_q   <= start_off;
                  cnt_q   <= '0;
                  state_q <= StIssue;
               end
            end
            StIssue: state_q <= bus.flush ? StIdle : StWait;
            StWait: begin
               if (bus.mem_rd_valid && bus.flush) begin
                  state_q <= StIdle;
               end else if (bus.mem_rd_valid) begin
                  line_q[off_q*WORD_W +: WORD_W] <= bus.mem_rd_data;
                  cnt_q   <= cnt_q + 1'b1;
                  // Offset wraps modulo the line, so the fetch never leaves it.
                  off_q   <= off_q + 1'b1;
                  state_q <= (cnt_q == LastCnt) ? StDone : StIssue;
               end else if (bus.flush) begin
                  state_q <= StDrain;
               end
            end
            StDone:  state_q <= StIdle;
            StDrain: if (bus.mem_rd_valid) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // A flush cancels the strobe or line pulse of the cycle it arrives in.
   assign bus.miss_ack   = accept;
   assign bus.busy       = (state_q != StIdle);
   assign bus.mem_rd_en  = (state_q == StIssue) && !bus.flush;
   assign bus.mem_addr   = base_q | ADDR_W'(off_q);
   assign bus.line_valid = (state_q == StDone) && !bus.flush;
   assign bus.line_addr  = base_q;
   assign bus.line_data  = line_q;
endmodule

// File: tb/tb_instr_line_refill.sv
// Randomised scoreboard bench for instr_line_refill: line/read-order model plus directed corner cases.
// Works in both builds; the model reads CRITICAL_WORD_FIRST_EN to pick the fetch order.
module tb_instr_line_refill;
   localparam int AW = 16;
   localparam int WW = 16;
   localparam int W  = 4;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [W*WW-1:0] data;
      int              due;
   } line_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   lat = 1;
   int   rd_cnt = 0;
   int   rd_base = 0;
   int   last_due = 0;

   logic [WW-1:0] mem_arr [0:65535];
   logic [AW-1:0] exp_rd_q [$];
   line_t         line_q [$];

   instr_line_refill_if #(.ADDR_W(AW), .WORD_W(WW), .WORDS_PER_LINE(W)) bus ();

   instr_line_refill #(.ADDR_W(AW), .WORD_W(WW), .WORDS_PER_LINE(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event required none (cycle %0d)", name, cyc);
   endtask

   // Memory: answers each strobe exactly lat cycles later and checks the address order.
   initial begin
      logic [AW-1:0] a;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_rd_en === 1'b1) begin
            rd_cnt++;
            if (exp_rd_q.size() == 0) fail("unexpected_read");
            else chk("read_addr", 64'(bus.mem_addr), 64'(exp_rd_q.pop_front()));
            a = bus.mem_addr;
            repeat (lat) @(posedge clk);
            #1;
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = mem_arr[a];
            @(posedge clk);
            #1;
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = 16'($urandom);
         end
      end
   end

   // Line monitor: every line pulse must match the oldest expected line.
   initial begin
      line_t e;
      forever begin
         @(negedge clk);
         if (bus.line_valid === 1'b1) begin
            if (line_q.size() == 0) begin
               fail("unexpected_line_valid");
            end else begin
               e = line_q.pop_front();
               chk("line_addr", 64'(bus.line_addr), 64'(e.addr));
               chk("line_data", bus.line_data, e.data);
               chk("line_cycle", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   task automatic send_req(input logic [AW-1:0] addr, input bit want_line, output int ack_cyc);
      line_t         e;
      logic [AW-1:0] base;
      int            start;
      @(posedge clk);
      #1;
      bus.miss_req  = 1'b1;
      bus.miss_addr = addr;
      bus.flush     = 1'b0;
      ack_cyc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.miss_ack === 1'b1) begin
            ack_cyc = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (ack_cyc < 0) begin
         fail("ack_timeout");
         return;
      end
      rd_base = rd_cnt;
      base = addr & ~16'(W - 1);
`ifdef CRITICAL_WORD_FIRST_EN
      start = int'(addr) % W;
`else
      start = 0;
`endif
      for (int k = 0; k < W; k++) exp_rd_q.push_back(base + 16'((start + k) % W));
      if (want_line) begin
         e.addr = base;
         e.data = '0;
         for (int k = 0; k < W; k++) e.data[k*WW +: WW] = mem_arr[base + 16'(k)];
         e.due = ack_cyc + 1 + W * (lat + 1);
         line_q.push_back(e);
         last_due = e.due;
      end
   endtask

   task automatic drop_req();
      @(posedge clk);
      #1;
      bus.miss_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("idle_timeout");
   endtask

   // Flush in the WAIT cycle right after the k-th read strobe of the current fill.
   task automatic flush_after(input int k);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (rd_cnt >= rd_base + k) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("flush_wait_timeout");
      #1;
      bus.flush = 1'b1;
      exp_rd_q.delete();
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_miss_ack"}, 64'(bus.miss_ack), 64'(0));
      chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
      chk({tag, "_mem_rd_en"}, 64'(bus.mem_rd_en), 64'(0));
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
      chk({tag, "_line_valid"}, 64'(bus.line_valid), 64'(0));
      chk({tag, "_line_addr"}, 64'(bus.line_addr), 64'(0));
      chk({tag, "_line_data"}, bus.line_data, 64'(0));
   endtask

   initial begin
      int ack;
      int ack2;
      int t0;
      int prev_due;
      bit chained;
      int kind;
      for (int i = 0; i < 65536; i++) mem_arr[i] = 16'($urandom);
      for (int i = 16; i < 20; i++) mem_arr[i] = 16'(i) ^ 16'hA000;
      rst_n         = 1'b0;
      bus.miss_req  = 1'b0;
      bus.miss_addr = '0;
      bus.flush     = 1'b0;
      lat           = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);

      // Basic fill (order depends on build), busy drops on the IDLE cycle.
      send_req(16'h0012, 1'b1, ack);
      drop_req();
      wait_idle();
      chk("fill_busy_drop_cycle", 64'(cyc), 64'(ack + 10));

      // Back-to-back: request held through DONE.
      send_req(16'h0012, 1'b1, ack);
      send_req(16'h0047, 1'b1, ack2);
      chk("b2b_ack_cycle", 64'(ack2), 64'(ack + 10));
      drop_req();
      wait_idle();

      // Flush and request together in IDLE.
      @(posedge clk);
      #1;
      bus.miss_req  = 1'b1;
      bus.miss_addr = 16'h0123;
      bus.flush     = 1'b1;
      @(negedge clk);
      chk("collision_no_ack", 64'(bus.miss_ack), 64'(0));
      t0 = cyc;
      send_req(16'h0123, 1'b1, ack);
      chk("collision_ack_next", 64'(ack), 64'(t0 + 1));
      drop_req();
      wait_idle();

      // Flush while waiting on the second word, L=3.
      lat = 3;
      send_req(16'h0200, 1'b0, ack);
      drop_req();
      flush_after(2);
      chk("drain_busy_a", 64'(bus.busy), 64'(1));
      @(negedge clk);
      chk("drain_busy_b", 64'(bus.busy), 64'(1));
      @(negedge clk);
      chk("drain_busy_done", 64'(bus.busy), 64'(0));
      chk("flush_read_count", 64'(rd_cnt - rd_base), 64'(2));
      t0 = cyc;
      send_req(16'h0306, 1'b1, ack);
      chk("after_flush_ack", 64'(ack), 64'(t0 + 1));
      drop_req();
      wait_idle();

      // Reset during WAIT, stray read data one cycle after release.
      send_req(16'h0408, 1'b0, ack);
      drop_req();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_rd_q.delete();
      @(negedge clk);
      chk_all_zero("midfill_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("stray_busy", 64'(bus.busy), 64'(0));
      chk("stray_line_data", bus.line_data, 64'(0));

      // Randomised fills, flushes and back-to-back chains.
      chained = 1'b0;
      for (int it = 0; it < 40; it++) begin
         if (!chained) begin
            wait_idle();
            lat = $urandom_range(1, 4);
         end
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            send_req(16'($urandom), 1'b0, ack);
            drop_req();
            flush_after($urandom_range(1, W));
            wait_idle();
            chained = 1'b0;
         end else begin
            prev_due = last_due;
            send_req(16'($urandom), 1'b1, ack);
            if (chained) chk("rand_b2b_ack", 64'(ack), 64'(prev_due + 1));
            chained = 1'($urandom_range(0, 1));
            if (!chained) drop_req();
         end
      end
      if (chained) drop_req();
      wait_idle();
      repeat (10) @(negedge clk);
      chk("lines_outstanding", 64'(line_q.size()), 64'(0));
      chk("reads_outstanding", 64'(exp_rd_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
